// File: rtl/hall_emu_pkg.sv
// Shared definitions for the hall-sensor motor emulator: select codes,
// hall-state sequencing and drive-pattern classification.
package hall_emu_pkg;

  localparam logic [1:0] FLOAT = 2'b00;
  localparam logic [1:0] LOW   = 2'b01;
  localparam logic [1:0] HIGH  = 2'b10;
  localparam logic [1:0] BRK   = 2'b11;

  // Hall state packed as {Grn, Ylw, Blu}; drive pattern as {G, Y, B}.
  typedef logic [2:0] hall_t;
  typedef logic [5:0] sel_pat_t;

  typedef enum logic [1:0] {
    CLS_MATCH,
    CLS_BRAKE,
    CLS_COAST,
    CLS_ERR
  } sel_class_t;

  localparam hall_t HALL_RESET = 3'b101;

  // Forward rotation only; an illegal state (000/111) recovers to 101.
  function automatic hall_t next_hall(input hall_t h);
    case (h)
      3'b101:  return 3'b100;
      3'b100:  return 3'b110;
      3'b110:  return 3'b010;
      3'b010:  return 3'b011;
      3'b011:  return 3'b001;
      3'b001:  return 3'b101;
      default: return HALL_RESET;
    endcase
  endfunction

  function automatic sel_pat_t expected_sel(input hall_t h);
    case (h)
      3'b101:  return {HIGH,  LOW,   FLOAT};
      3'b100:  return {HIGH,  FLOAT, LOW};
      3'b110:  return {FLOAT, HIGH,  LOW};
      3'b010:  return {LOW,   HIGH,  FLOAT};
      3'b011:  return {LOW,   FLOAT, HIGH};
      3'b001:  return {FLOAT, LOW,   HIGH};
      default: return {FLOAT, FLOAT, FLOAT};
    endcase
  endfunction

  // Brake and coast are recognised first so an illegal hall state can never
  // turn an all-float pattern into a match.
  function automatic sel_class_t classify(input sel_pat_t sel, input hall_t h);
    if (sel == {BRK, BRK, BRK})
      return CLS_BRAKE;
    else if (sel == {FLOAT, FLOAT, FLOAT})
      return CLS_COAST;
    else if (sel == expected_sel(h))
      return CLS_MATCH;
    else
      return CLS_ERR;
  endfunction

endpackage

// File: rtl/hall_speed_model.sv
// Prescaled speed model: every 2^UPD_W clocks the drive pattern is classified
// against the current hall state and speed is updated with torque and drag.
module hall_speed_model
  import hall_emu_pkg::*;
#(
  parameter int UPD_W       = 10,
  parameter int TORQ_SHIFT  = 2,
  parameter int DRAG_SHIFT  = 6,
  parameter int BRAKE_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  sel,
  input  logic [10:0] duty,
  input  logic [2:0]  hall,
  output logic [15:0] speed,
  output logic        tick,
  output logic        commut_err
);

  logic [UPD_W-1:0] presc;
  sel_class_t       cls;
  logic [17:0]      speed_ext;
  logic [17:0]      torque;
  logic [17:0]      drag;
  logic [17:0]      brake_drag;
  logic [17:0]      raw;
  logic [15:0]      next_speed;

  assign tick       = &presc;
  assign cls        = classify(sel, hall);
  assign speed_ext  = {2'b00, speed};
  // duty[10] set means duty >= 0x400, so duty[9:0] is the excess over zero torque.
  assign torque     = duty[10] ? ({8'b0, duty[9:0]} >> TORQ_SHIFT) : '0;
  assign drag       = speed_ext >> DRAG_SHIFT;
  assign brake_drag = speed_ext >> BRAKE_SHIFT;

  // Bit 17 acts as the sign of the 18-bit result; the largest positive
  // value (0xFFFF + 0xFF) never reaches it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    raw        = speed_ext - drag;
    next_speed = raw[15:0];
    case (cls)
      CLS_MATCH: raw = speed_ext + torque - drag;
      CLS_BRAKE: raw = speed_ext - brake_drag - 18'd1;
      default:   raw = speed_ext - drag;
    endcase
    if (raw[17])
      next_speed = '0;
    else if (raw[16])
      next_speed = '1;
    else
      next_speed = raw[15:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      speed      <= '0;
      commut_err <= 1'b0;
    end else begin
      presc <= presc + UPD_W'(1);
      if (tick) begin
        speed      <= next_speed;
        commut_err <= (cls == CLS_ERR);
      end
    end
  end

endmodule

// File: rtl/hall_emulator.sv
// Closed-loop brushless motor model: integrates speed into rotor position and
// emits the three hall signals plus a step count for the commutation logic.
module hall_emulator
  import hall_emu_pkg::*;
#(
  parameter int PHASE_W     = 20,
  parameter int UPD_W       = 10,
  parameter int TORQ_SHIFT  = 2,
  parameter int DRAG_SHIFT  = 6,
  parameter int BRAKE_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  selGrn,
  input  logic [1:0]  selYlw,
  input  logic [1:0]  selBlu,
  input  logic [10:0] duty,
  output logic        hallGrn,
  output logic        hallYlw,
  output logic        hallBlu,
  output logic [15:0] speed,
  output logic [15:0] step_cnt,
  output logic        commut_err
);

  hall_t              hall;
  hall_t              hall_next;
  logic [15:0]        step_next;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0]   phase_sum;

  // The speed model classifies against the registered hall state, so a tick
  // coinciding with a step sees the pre-step value.
  hall_speed_model #(
    .UPD_W       (UPD_W),
    .TORQ_SHIFT  (TORQ_SHIFT),
    .DRAG_SHIFT  (DRAG_SHIFT),
    .BRAKE_SHIFT (BRAKE_SHIFT)
  ) u_speed (
    .clk        (clk),
    .rst        (rst),
    .sel        ({selGrn, selYlw, selBlu}),
    .duty       (duty),
    .hall       (hall),
    .speed      (speed),
    .tick       (),
    .commut_err (commut_err)
  );

  // Speed is zero-extended into the PHASE_W+1 bit sum; bit PHASE_W is the carry.
  assign phase_sum = {1'b0, phase} + {{(PHASE_W - 15){1'b0}}, speed};

  always_comb begin
    hall_next = hall;
    step_next = step_cnt;
    if (phase_sum[PHASE_W]) begin
      hall_next = next_hall(hall);
      step_next = step_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hall     <= HALL_RESET;
      phase    <= '0;
      step_cnt <= '0;
    end else begin
      hall     <= hall_next;
      phase    <= phase_sum[PHASE_W-1:0];
      step_cnt <= step_next;
    end
  end

  assign {hallGrn, hallYlw, hallBlu} = hall;

endmodule

// File: tb/tb_hall_emulator.sv
// Scoreboarded bench for hall_emulator: a position/speed reference model pushes
// the expected outputs every clock and a monitor compares them on the falling edge.
module tb_hall_emulator;

  // A short update period keeps the run brief; torque/drag/position sizes are default.
  localparam int PHASE_W     = 20;
  localparam int UPD_W       = 6;
  localparam int TORQ_SHIFT  = 2;
  localparam int DRAG_SHIFT  = 6;
  localparam int BRAKE_SHIFT = 3;
  localparam int TICK_CYC    = 1 << UPD_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  sel_bus = 6'b0;
  logic [10:0] duty = 11'h400;
  logic [1:0]  selGrn, selYlw, selBlu;
  logic        hallGrn, hallYlw, hallBlu;
  logic [15:0] speed, step_cnt;
  logic        commut_err;

  assign {selGrn, selYlw, selBlu} = sel_bus;

  hall_emulator #(
    .PHASE_W     (PHASE_W),
    .UPD_W       (UPD_W),
    .TORQ_SHIFT  (TORQ_SHIFT),
    .DRAG_SHIFT  (DRAG_SHIFT),
    .BRAKE_SHIFT (BRAKE_SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .selGrn     (selGrn),
    .selYlw     (selYlw),
    .selBlu     (selBlu),
    .duty       (duty),
    .hallGrn    (hallGrn),
    .hallYlw    (hallYlw),
    .hallBlu    (hallBlu),
    .speed      (speed),
    .step_cnt   (step_cnt),
    .commut_err (commut_err)
  );

  always #5 clk = ~clk;

  // Rotation order and the drive pattern each hall position expects.
  logic [2:0] seq_tab [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  logic [5:0] pat_tab [6] = '{6'b100100, 6'b100001, 6'b001001,
                              6'b011000, 6'b010010, 6'b000110};

  typedef struct {
    logic [2:0]  hall;
    logic [15:0] speed;
    logic [15:0] steps;
    logic        err;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_err    = 0;

  // Reference model state: total accumulated position as one wide integer.
  int     m_speed = 0;
  int     m_cyc   = 0;
  int     m_ticks = 0;
  longint m_pos   = 0;
  bit     m_err   = 1'b0;

  typedef enum {DRV_FIXED, DRV_FOLLOW, DRV_GREEDY} drv_mode_t;
  drv_mode_t mode = DRV_FIXED;
  int        follow_duty = 'h400;
  int        target = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_true(input string name, input bit cond, input logic [31:0] got);
    n_checks++;
    if (!cond) begin
      n_err++;
      $display("FAIL %s: condition false, observed 0x%0h (t=%0t)", name, got, $time);
    end
  endtask

  function automatic int hall_idx(input logic [2:0] h);
    for (int i = 0; i < 6; i++)
      if (seq_tab[i] == h) return i;
    return -1;
  endfunction

  function automatic int model_next_speed(input int s, input logic [5:0] sel,
                                          input int idx, input logic [10:0] d);
    int n;
    int excess;
    excess = (int'(d) > 1024) ? int'(d) - 1024 : 0;
    if (sel == 6'b111111)
      n = s - (s >> BRAKE_SHIFT) - 1;
    else if (sel != 6'b000000 && sel == pat_tab[idx])
      n = s + (excess >> TORQ_SHIFT) - (s >> DRAG_SHIFT);
    else
      n = s - (s >> DRAG_SHIFT);
    if (n < 0) n = 0;
    if (n > 65535) n = 65535;
    return n;
  endfunction

  // Reference model: advances once per rising edge using the same inputs the DUT sees.
  initial begin
    int    idx;
    bit    is_tick;
    snap_t s;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_speed = 0;
        m_pos   = 0;
        m_cyc   = 0;
        m_err   = 1'b0;
      end else begin
        idx     = int'((m_pos >> PHASE_W) % 6);
        is_tick = (m_cyc % TICK_CYC) == TICK_CYC - 1;
        m_pos   = m_pos + longint'(m_speed);
        if (is_tick) begin
          m_err   = !(sel_bus == 6'b111111 || sel_bus == 6'b000000 || sel_bus == pat_tab[idx]);
          m_speed = model_next_speed(m_speed, sel_bus, idx, duty);
          m_ticks++;
        end
        m_cyc++;
      end
      s.hall  = seq_tab[int'((m_pos >> PHASE_W) % 6)];
      s.speed = 16'(m_speed);
      s.steps = 16'((m_pos >> PHASE_W) & 64'hFFFF);
      s.err   = m_err;
      exp_q.push_back(s);
    end
  end

  // Monitor: one expected record per clock, compared away from the active edge.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!rst) begin
          n_checks++;
          if ({hallGrn, hallYlw, hallBlu} !== e.hall || speed !== e.speed ||
              step_cnt !== e.steps || commut_err !== e.err) begin
            n_err++;
            $display("FAIL scoreboard t=%0t: got hall=%b speed=%h steps=%h err=%b, want hall=%b speed=%h steps=%h err=%b",
                     $time, {hallGrn, hallYlw, hallBlu}, speed, step_cnt, commut_err,
                     e.hall, e.speed, e.steps, e.err);
          end
        end
      end
    end
  end

  // Closed-loop driver: follows the DUT's hall outputs like the commutation logic would.
  initial begin
    int         idx;
    int         t;
    logic [5:0] pat;
    forever begin
      @(negedge clk);
      if (mode != DRV_FIXED) begin
        idx = hall_idx({hallGrn, hallYlw, hallBlu});
        pat = (idx < 0) ? 6'b0 : pat_tab[idx];
        if (mode == DRV_FOLLOW) begin
          sel_bus = pat;
          duty    = follow_duty[10:0];
        end else begin
          t = target - m_speed + (m_speed >> DRAG_SHIFT);
          if (t < 0) begin
            sel_bus = 6'b0;
            duty    = 11'h400;
          end else if (t > 255) begin
            sel_bus = pat;
            duty    = 11'h7FF;
          end else begin
            sel_bus = pat;
            duty    = 11'(1024 + (t << TORQ_SHIFT));
          end
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    int start;
    int budget;
    start  = m_ticks;
    budget = n * TICK_CYC + 4;
    while (m_ticks < start + n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (m_ticks < start + n) check_true("tick_timeout", 1'b0, 32'(m_ticks));
  endtask

  task automatic drive_to(input int tgt);
    int budget;
    target = tgt;
    mode   = DRV_GREEDY;
    budget = 300 * TICK_CYC;
    while (m_speed != tgt && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drive_to_speed", 32'(speed), 32'(tgt));
  endtask

  task automatic do_reset();
    mode    = DRV_FIXED;
    sel_bus = 6'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  prev_h;
    logic [2:0]  cur_h;
    logic [15:0] prev_step;
    logic [15:0] prev_spd;
    int          changes;
    bit          err_seen;
    int          budget;
    int          settle_start;
    int          kind;
    int          len;

    // Reset state, then a long coast at zero speed.
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_halls", 32'({hallGrn, hallYlw, hallBlu}), 32'b101);
    check("rst_speed", 32'(speed), 0);
    check("rst_steps", 32'(step_cnt), 0);
    check("rst_err", 32'(commut_err), 0);
    rst = 1'b0;
    repeat (5000) @(negedge clk);
    check("coast_halls", 32'({hallGrn, hallYlw, hallBlu}), 32'b101);
    check("coast_steps", 32'(step_cnt), 0);

    // Matching drive at H=101 with duty 0x600.
    sel_bus = 6'b100100;
    duty    = 11'h600;
    wait_ticks(1);
    check("accel_tick1", 32'(speed), 32'h0080);
    check("accel_err1", 32'(commut_err), 0);
    wait_ticks(1);
    check("accel_tick2", 32'(speed), 32'h00FE);
    check("accel_err2", 32'(commut_err), 0);

    // Closed loop at full torque until speed settles.
    follow_duty  = 'h7FF;
    mode         = DRV_FOLLOW;
    prev_h       = {hallGrn, hallYlw, hallBlu};
    prev_step    = step_cnt;
    changes      = 0;
    err_seen     = 1'b0;
    settle_start = -1;
    budget       = 800 * TICK_CYC;
    while (budget > 0) begin
      @(negedge clk);
      budget--;
      cur_h = {hallGrn, hallYlw, hallBlu};
      if (cur_h != prev_h) begin
        check("hall_seq", 32'(cur_h), 32'(seq_tab[(hall_idx(prev_h) + 1) % 6]));
        check("step_inc", 32'(step_cnt), 32'(16'(prev_step + 16'd1)));
        changes++;
        prev_h    = cur_h;
        prev_step = step_cnt;
      end
      if (commut_err) err_seen = 1'b1;
      if (settle_start < 0 && m_speed >= 'h3FC0) settle_start = m_ticks;
      if (settle_start >= 0 && m_ticks >= settle_start + 8) break;
    end
    check_true("settle_window", speed >= 16'h3FC0 && speed <= 16'h3FFF, 32'(speed));
    check("loop_no_err", 32'(err_seen), 0);
    check_true("loop_full_rev", changes >= 6, 32'(changes));

    // Brake from 0x1000 down to standstill.
    do_reset();
    drive_to('h1000);
    mode    = DRV_FIXED;
    sel_bus = 6'b111111;
    wait_ticks(1);
    check("brake_first", 32'(speed), 32'h0DFF);
    prev_spd = speed;
    for (int k = 0; k < 100 && speed != 16'd0; k++) begin
      wait_ticks(1);
      check_true("brake_monotonic", speed < prev_spd, 32'(speed));
      prev_spd = speed;
    end
    check("brake_zero", 32'(speed), 0);
    prev_h    = {hallGrn, hallYlw, hallBlu};
    prev_step = step_cnt;
    repeat (1000) @(negedge clk);
    check("freeze_halls", 32'({hallGrn, hallYlw, hallBlu}), 32'(prev_h));
    check("freeze_steps", 32'(step_cnt), 32'(prev_step));

    // Asynchronous reset mid-rotation.
    do_reset();
    drive_to('h2000);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #2;
    rst     = 1'b1;
    mode    = DRV_FIXED;
    sel_bus = 6'b0;
    #1;
    check("async_halls", 32'({hallGrn, hallYlw, hallBlu}), 32'b101);
    check("async_speed", 32'(speed), 0);
    check("async_steps", 32'(step_cnt), 0);
    check("async_err", 32'(commut_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ticks(3);
    check("post_rst_steps", 32'(step_cnt), 0);
    check("post_rst_halls", 32'({hallGrn, hallYlw, hallBlu}), 32'b101);

    // Wrong pattern at H=101, then recovery on a matching tick.
    drive_to('h100);
    mode    = DRV_FIXED;
    sel_bus = 6'b001001;
    wait_ticks(1);
    check("wrong_err", 32'(commut_err), 1);
    check("wrong_speed", 32'(speed), 32'h00FC);
    follow_duty = 'h400;
    mode        = DRV_FOLLOW;
    wait_ticks(1);
    check("match_clears_err", 32'(commut_err), 0);
    check("match_zero_torque", 32'(speed), 32'h00F9);

    // Random segments of drive, brake, coast and arbitrary patterns.
    for (int seg = 0; seg < 30; seg++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(40, 400);
      case (kind)
        0: begin
          follow_duty = $urandom_range(0, 2047);
          mode        = DRV_FOLLOW;
        end
        1: begin
          mode    = DRV_FIXED;
          sel_bus = 6'b111111;
        end
        2: begin
          mode    = DRV_FIXED;
          sel_bus = 6'b000000;
        end
        default: begin
          mode    = DRV_FIXED;
          sel_bus = 6'($urandom);
          duty    = 11'($urandom);
        end
      endcase
      repeat (len) @(negedge clk);
    end

    mode = DRV_FIXED;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
